// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: adds two packed BCD operands one decimal digit per clock,
// LSD first, with a registered decimal carry between digits.

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);
  logic [4:0] t;

  always_comb begin
    t   = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    co  = (t > 5'd9);
    // +6 skips the six unused codes; wraps mod 16 for out-of-range digits
    s   = co ? (t[3:0] + 4'd6) : t[3:0];
    bad = (a > 4'd9) || (b > 4'd9);
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   SUM,
  output logic                  COUT,
  output logic                  ERR
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] a;
    logic [DIGITS-1:0][3:0] b;
  } opnd_t;

  state_t                 state;
  opnd_t                  op_q;
  logic [DIGITS-1:0][3:0] sum_q;
  logic                   cy;
  logic [IW-1:0]          idx;

  logic [3:0] dig_s;
  logic       dig_co;
  logic       dig_bad;

  bcd_digit_add u_dig (
    .a   (op_q.a[idx]),
    .b   (op_q.b[idx]),
    .ci  (cy),
    .s   (dig_s),
    .co  (dig_co),
    .bad (dig_bad)
  );

  assign SUM = sum_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      op_q  <= '0;
      sum_q <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      COUT  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          op_q.a <= A;
          op_q.b <= B;
          sum_q  <= '0;
          cy     <= 1'b0;
          idx    <= '0;
          COUT   <= 1'b0;
          ERR    <= 1'b0;
          BUSY   <= 1'b1;
          state  <= S_RUN;
        end
        S_RUN: begin
          sum_q[idx] <= dig_s;
          cy         <= dig_co;
          if (dig_bad) ERR <= 1'b1;
          if (idx == IW'(DIGITS - 1)) begin
            COUT  <= dig_co;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4): vector table plus corner sequences.

module tb_bcd_serial_adder;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        BUSY, DONE, COUT, ERR;
  logic [15:0] SUM;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts from #1 after a posedge; returns edges from acceptance to DONE rising (-1 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    START = 1'b1; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = n; break; end
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   prev, k;

  initial begin
    vecs[0] = '{16'h0358, 16'h0046, 16'h0404, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0009, 16'h0009, 16'h0018, 1'b0, 1'b0};
    vecs[3] = '{16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h8765, 16'h9999, 1'b0, 1'b0};
    vecs[5] = '{16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1};
    vecs[6] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0};
    vecs[7] = '{16'h0FFF, 16'h0FFF, 16'h1554, 1'b0, 1'b1};

    // reset state
    #12;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_sum",  {16'd0, SUM},  32'd0);
    chk("rst_cout", {31'd0, COUT}, 32'd0);
    chk("rst_err",  {31'd0, ERR},  32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      chk($sformatf("v%0d_sum", i),  {16'd0, SUM},  {16'd0, vecs[i].sum});
      chk($sformatf("v%0d_cout", i), {31'd0, COUT}, {31'd0, vecs[i].cout});
      chk($sformatf("v%0d_err", i),  {31'd0, ERR},  {31'd0, vecs[i].err});
      @(posedge CLK); #1;
      chk($sformatf("v%0d_busy_fall", i), {30'd0, BUSY, DONE}, 32'd0);
    end

    // ERR sticky through idle, then cleared by next START
    run_op(16'h00A0, 16'h0000, lat);
    repeat (4) @(posedge CLK);
    #1;
    chk("err_sticky", {31'd0, ERR}, 32'd1);
    chk("sum_hold",   {16'd0, SUM}, 32'h0100);
    run_op(16'h0001, 16'h0002, lat);
    chk("err_clr_sum", {16'd0, SUM}, 32'h0003);
    chk("err_clr_err", {31'd0, ERR}, 32'd0);
    @(posedge CLK); #1;

    // START re-asserted through RUN and DONE with other operands is ignored
    START = 1'b1; A = 16'h1234; B = 16'h8765;
    @(posedge CLK); #1;
    lat = -1;
    for (int n = 1; n <= 5; n++) begin
      A = 16'h0000 + 16'(n * 16'h1111); B = 16'h4321;
      @(posedge CLK); #1;
      if (DONE && lat < 0) lat = n;
    end
    START = 1'b0;
    chk("ign_latency", lat, 32'd4);
    chk("ign_sum",  {16'd0, SUM},  32'h9999);
    chk("ign_cout", {31'd0, COUT}, 32'd0);
    @(posedge CLK); #1;
    chk("ign_no_restart", {31'd0, BUSY}, 32'd0);

    // START held high: DONE every DIGITS+2 cycles
    START = 1'b1; A = 16'h0358; B = 16'h0046;
    k = 0; prev = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        if (k > 0) chk($sformatf("b2b_period%0d", k), cyc - prev, 32'd6);
        prev = cyc;
        k++;
        if (k == 4) break;
      end
    end
    chk("b2b_pulses", k, 32'd4);
    chk("b2b_sum", {16'd0, SUM}, 32'h0404);
    START = 1'b0;
    for (int n = 0; n < 10 && BUSY; n++) begin @(posedge CLK); #1; end
    chk("b2b_idle", {31'd0, BUSY}, 32'd0);

    // asynchronous reset mid-RUN after two digits
    run_op(16'h5000, 16'h5000, lat);
    chk("pre_cout", {31'd0, COUT}, 32'd1);
    @(posedge CLK); #1;
    START = 1'b1; A = 16'h0358; B = 16'h0046;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("mid_partial_sum", {16'd0, SUM}, 32'h0004);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_sum",  {16'd0, SUM},  32'd0);
    chk("mid_rst_cout", {31'd0, COUT}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    run_op(16'h9999, 16'h0001, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_sum",  {16'd0, SUM},  32'h0000);
    chk("post_rst_cout", {31'd0, COUT}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
